// File: rtl/halt_dump_ctrl.sv
// halt_dump_ctrl
//   Watches the core for a halt-and-catch-fire (hcf) or a run-cycle timeout.
//   On either trigger it reads DUMP_WORDS consecutive words from memory,
//   starting at BASE_ADDR, and presents them one at a time on a
//   valid/ready dump port. When the dump is finished it reports done and
//   stays idle until reset.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   hcf          halt-and-catch-fire level from the core
//   mem_req      one-cycle read strobe; mem_addr is valid with it
//   mem_addr     read byte address
//   mem_rvalid   read data valid (1..N cycles after mem_req)
//   mem_rdata    read data
//   dout_valid   dump word available
//   dout_ready   consumer accepts the dump word
//   dout_addr    byte address of the dump word
//   dout_data    dump word
//   done         dump finished (sticky until reset)
//   timeout      dump was forced by the cycle limit (sticky until reset)
//   cycle_count  run cycles counted before the trigger
//
// state | meaning
// ------+-----------------------------------------------------------
// RUN   | core running; count cycles, wait for hcf or the cycle limit
// REQ   | mem_req strobe for the current address
// WAIT  | wait for mem_rvalid, capture the word
// OUT   | present the word until the consumer takes it
// DONE  | dump complete; idle until reset
module halt_dump_ctrl #(
    parameter int                ADDR_W     = 16,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(16'h8000),
    parameter int                DUMP_WORDS = 32,
    parameter int                TIMEOUT    = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hcf,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [ADDR_W-1:0] dout_addr,
    output logic [DATA_W-1:0] dout_data,
    output logic              done,
    output logic              timeout,
    output logic [31:0]       cycle_count
);

    localparam int                IDX_W     = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DUMP_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);
    // Terminal count: the trigger fires on the cycle the counter reads TIMEOUT-1.
    localparam logic [31:0]       TC_COUNT  = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        RUN,
        REQ,
        WAIT,
        OUT,
        DONE
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;

    // mem_addr doubles as the current dump address register; it is only
    // meaningful to the memory while mem_req is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            idx         <= '0;
            cycle_count <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
            dout_valid  <= 1'b0;
            dout_addr   <= '0;
            dout_data   <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    // hcf has priority: a simultaneous limit hit is not a timeout.
                    if (hcf) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= BASE_ADDR;
                        idx      <= '0;
                    end else if (cycle_count == TC_COUNT) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= BASE_ADDR;
                        idx      <= '0;
                        timeout  <= 1'b1;
                    end else if (cycle_count != 32'hFFFF_FFFF) begin
                        cycle_count <= cycle_count + 32'd1;
                    end
                end
                REQ: begin
                    mem_req <= 1'b0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        dout_data  <= mem_rdata;
                        dout_addr  <= mem_addr;
                        dout_valid <= 1'b1;
                        state      <= OUT;
                    end
                end
                OUT: begin
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx      <= idx + 1'b1;
                            mem_addr <= mem_addr + ADDR_STEP;
                            mem_req  <= 1'b1;
                            state    <= REQ;
                        end
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_halt_dump_ctrl.sv
// Directed bench for halt_dump_ctrl. Three instances:
//   dut_a : defaults; hcf dump, hcf toggling after trigger, mid-dump reset
//   dut_t : TIMEOUT=50; forced dump and hcf/timeout collision
//   dut_w : BASE_ADDR=FFF8, DUMP_WORDS=4; address wrap with a 0,0,1 ready pattern
// Each memory model returns rdata = {16'h0, addr} two cycles after mem_req.
module tb_halt_dump_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // ---------------- dut_a ----------------
    logic        rst_a, hcf_a, mem_req_a, mem_rvalid_a, dout_valid_a, dout_ready_a;
    logic        done_a, timeout_a;
    logic [15:0] mem_addr_a, dout_addr_a;
    logic [31:0] mem_rdata_a, dout_data_a, cc_a;

    halt_dump_ctrl dut_a (
        .clk(clk), .rst(rst_a), .hcf(hcf_a),
        .mem_req(mem_req_a), .mem_addr(mem_addr_a),
        .mem_rvalid(mem_rvalid_a), .mem_rdata(mem_rdata_a),
        .dout_valid(dout_valid_a), .dout_ready(dout_ready_a),
        .dout_addr(dout_addr_a), .dout_data(dout_data_a),
        .done(done_a), .timeout(timeout_a), .cycle_count(cc_a)
    );

    // ---------------- dut_t ----------------
    logic        rst_t, hcf_t, mem_req_t, mem_rvalid_t, dout_valid_t, dout_ready_t;
    logic        done_t, timeout_t;
    logic [15:0] mem_addr_t, dout_addr_t;
    logic [31:0] mem_rdata_t, dout_data_t, cc_t;

    halt_dump_ctrl #(.TIMEOUT(50)) dut_t (
        .clk(clk), .rst(rst_t), .hcf(hcf_t),
        .mem_req(mem_req_t), .mem_addr(mem_addr_t),
        .mem_rvalid(mem_rvalid_t), .mem_rdata(mem_rdata_t),
        .dout_valid(dout_valid_t), .dout_ready(dout_ready_t),
        .dout_addr(dout_addr_t), .dout_data(dout_data_t),
        .done(done_t), .timeout(timeout_t), .cycle_count(cc_t)
    );

    // ---------------- dut_w ----------------
    logic        rst_w, hcf_w, mem_req_w, mem_rvalid_w, dout_valid_w, dout_ready_w;
    logic        done_w, timeout_w;
    logic [15:0] mem_addr_w, dout_addr_w;
    logic [31:0] mem_rdata_w, dout_data_w, cc_w;

    halt_dump_ctrl #(.BASE_ADDR(16'hFFF8), .DUMP_WORDS(4)) dut_w (
        .clk(clk), .rst(rst_w), .hcf(hcf_w),
        .mem_req(mem_req_w), .mem_addr(mem_addr_w),
        .mem_rvalid(mem_rvalid_w), .mem_rdata(mem_rdata_w),
        .dout_valid(dout_valid_w), .dout_ready(dout_ready_w),
        .dout_addr(dout_addr_w), .dout_data(dout_data_w),
        .done(done_w), .timeout(timeout_w), .cycle_count(cc_w)
    );

    // ---------------- memory models (2-cycle latency, rdata = addr) ----------------
    logic [1:0]  pv_a = '0, pv_t = '0, pv_w = '0;
    logic [15:0] pa_a0 = '0, pa_a1 = '0, pa_t0 = '0, pa_t1 = '0, pa_w0 = '0, pa_w1 = '0;

    always @(posedge clk) begin
        pv_a  <= {pv_a[0], mem_req_a};
        pa_a0 <= mem_addr_a;
        pa_a1 <= pa_a0;
        pv_t  <= {pv_t[0], mem_req_t};
        pa_t0 <= mem_addr_t;
        pa_t1 <= pa_t0;
        pv_w  <= {pv_w[0], mem_req_w};
        pa_w0 <= mem_addr_w;
        pa_w1 <= pa_w0;
    end

    assign mem_rvalid_a = pv_a[1];
    assign mem_rdata_a  = {16'h0, pa_a1};
    assign mem_rvalid_t = pv_t[1];
    assign mem_rdata_t  = {16'h0, pa_t1};
    assign mem_rvalid_w = pv_w[1];
    assign mem_rdata_w  = {16'h0, pa_w1};

    // ---------------- consumers / monitors ----------------
    logic [15:0] qa_addr[$];
    logic [31:0] qa_data[$];
    logic [15:0] qw_addr[$];
    logic [31:0] qw_data[$];
    logic        hold_w = 1'b0;
    logic [15:0] held_addr_w = '0;
    logic [31:0] held_data_w = '0;
    int          hold_cnt = 0;

    always @(negedge clk) begin
        if (dout_valid_a && dout_ready_a) begin
            qa_addr.push_back(dout_addr_a);
            qa_data.push_back(dout_data_a);
        end
        if (dout_valid_w && dout_ready_w) begin
            qw_addr.push_back(dout_addr_w);
            qw_data.push_back(dout_data_w);
        end
        // a word left waiting must not change while it is still offered
        if (hold_w && dout_valid_w) begin
            check("w_hold_addr", dout_addr_w, held_addr_w);
            check("w_hold_data", dout_data_w, held_data_w);
            hold_cnt <= hold_cnt + 1;
        end
        hold_w      <= dout_valid_w && !dout_ready_w;
        held_addr_w <= dout_addr_w;
        held_data_w <= dout_data_w;
    end

    // ready pattern 0,0,1 for dut_w
    int rc = 0;
    initial begin
        dout_ready_w = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rc++;
            dout_ready_w = (rc % 3 == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    logic [15:0] exp_w [4];
    logic [15:0] ea;
    int          n;

    initial begin
        exp_w = '{16'hFFF8, 16'hFFFC, 16'h0000, 16'h0004};
        rst_a = 1'b0; rst_t = 1'b0; rst_w = 1'b0;
        hcf_a = 1'b0; hcf_t = 1'b0; hcf_w = 1'b0;
        dout_ready_a = 1'b1; dout_ready_t = 1'b1;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_cycle_count", cc_a, 0);
        check("rst_mem_req", mem_req_a, 0);
        check("rst_mem_addr", mem_addr_a, 0);
        check("rst_dout_valid", dout_valid_a, 0);
        check("rst_dout_addr", dout_addr_a, 0);
        check("rst_dout_data", dout_data_a, 0);
        check("rst_done", done_a, 0);
        check("rst_timeout", timeout_a, 0);

        // forced dump after 50 run cycles
        rst_t = 1'b1;
        n = 0;
        while (!mem_req_t && n < 100) begin @(negedge clk); n++; end
        check("t_req_seen", mem_req_t, 1);
        check("t_timeout", timeout_t, 1);
        check("t_cycle_count", cc_t, 49);
        check("t_first_addr", mem_addr_t, 16'h8000);
        @(negedge clk);
        check("t_req_one_cycle", mem_req_t, 0);

        // hcf on the limit cycle wins
        rst_t = 1'b0;
        #1;
        check("t_async_timeout_clr", timeout_t, 0);
        check("t_async_cc_clr", cc_t, 0);
        @(negedge clk);
        rst_t = 1'b1;
        n = 0;
        while (cc_t != 49 && n < 100) begin @(negedge clk); n++; end
        check("t2_cc_reach", cc_t, 49);
        hcf_t = 1'b1;
        @(negedge clk);
        check("t2_req", mem_req_t, 1);
        check("t2_timeout", timeout_t, 0);
        check("t2_cc_frozen", cc_t, 49);
        repeat (20) @(negedge clk);
        check("t2_timeout_late", timeout_t, 0);

        // address wrap with ready backpressure
        rst_w = 1'b1;
        hcf_w = 1'b1;
        n = 0;
        while (!done_w && n < 300) begin @(negedge clk); n++; end
        check("w_done", done_w, 1);
        @(negedge clk);
        check("w_count", qw_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < qw_addr.size()) begin
                check("w_addr", qw_addr[i], exp_w[i]);
                check("w_data", qw_data[i], {16'h0, exp_w[i]});
            end
        end
        check("w_hold_seen", hold_cnt > 0, 1);
        check("w_done_valid", dout_valid_w, 0);
        check("w_done_req", mem_req_w, 0);

        // default dump triggered at run cycle 100
        rst_a = 1'b1;
        n = 0;
        while (cc_a != 100 && n < 300) begin @(negedge clk); n++; end
        check("a_cc_reach", cc_a, 100);
        hcf_a = 1'b1;
        n = 0;
        while (!done_a && n < 2000) begin @(negedge clk); n++; end
        check("a_done", done_a, 1);
        @(negedge clk);
        check("a_count", qa_addr.size(), 32);
        for (int i = 0; i < 32; i++) begin
            ea = 16'(16'h8000 + i * 4);
            if (i < qa_addr.size()) begin
                check("a_addr", qa_addr[i], ea);
                check("a_data", qa_data[i], {16'h0, ea});
            end
        end
        check("a_cycle_count", cc_a, 100);
        check("a_timeout", timeout_a, 0);

        // hcf toggling after the dump has no effect
        hcf_a = 1'b0;
        repeat (3) @(negedge clk);
        hcf_a = 1'b1;
        repeat (3) @(negedge clk);
        check("a_done_sticky", done_a, 1);
        check("a_cc_frozen", cc_a, 100);
        check("a_no_extra_words", qa_addr.size(), 32);
        check("a_done_req", mem_req_a, 0);
        check("a_done_valid", dout_valid_a, 0);

        // reset during the fifth word's WAIT
        rst_a = 1'b0;
        hcf_a = 1'b0;
        @(negedge clk);
        rst_a = 1'b1;
        qa_addr.delete();
        qa_data.delete();
        n = 0;
        while (cc_a != 10 && n < 100) begin @(negedge clk); n++; end
        hcf_a = 1'b1;
        n = 0;
        while (qa_addr.size() < 4 && n < 200) begin @(negedge clk); n++; end
        check("r_four_words", qa_addr.size(), 4);
        n = 0;
        while (!mem_req_a && n < 20) begin @(negedge clk); n++; end
        check("r_word5_req", mem_req_a, 1);
        check("r_word5_addr", mem_addr_a, 16'h8010);
        @(negedge clk);
        check("r_in_wait", dout_valid_a, 0);
        #2;
        rst_a = 1'b0;
        hcf_a = 1'b0;
        #1;
        check("r_cycle_count", cc_a, 0);
        check("r_mem_req", mem_req_a, 0);
        check("r_mem_addr", mem_addr_a, 0);
        check("r_dout_valid", dout_valid_a, 0);
        check("r_dout_addr", dout_addr_a, 0);
        check("r_dout_data", dout_data_a, 0);
        check("r_done", done_a, 0);
        check("r_timeout", timeout_a, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("r_no_req_in_reset", mem_req_a, 0);
        end
        qa_addr.delete();
        qa_data.delete();
        rst_a = 1'b1;
        n = 0;
        while (cc_a != 20 && n < 100) begin @(negedge clk); n++; end
        check("r_cc_reach", cc_a, 20);
        check("r_no_stray_words", qa_addr.size(), 0);
        hcf_a = 1'b1;
        @(negedge clk);
        check("r_restart_req", mem_req_a, 1);
        check("r_restart_addr", mem_addr_a, 16'h8000);
        n = 0;
        while (!done_a && n < 2000) begin @(negedge clk); n++; end
        check("r_done_again", done_a, 1);
        @(negedge clk);
        check("r_count", qa_addr.size(), 32);
        if (qa_addr.size() == 32) begin
            check("r_first_addr", qa_addr[0], 16'h8000);
            check("r_last_addr", qa_addr[31], 16'h807C);
            check("r_last_data", qa_data[31], 32'h0000_807C);
        end
        check("r_cycle_count_final", cc_a, 20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/halt_dump_ctrl.md
HALT_DUMP_CTRL -- requirements
Module: halt_dump_ctrl

Interface
REQ-001 Parameter ADDR_W, default 16, memory byte-address width.
REQ-002 Parameter DATA_W, default 32, memory word width; SHALL be a multiple of 8.
REQ-003 Parameter BASE_ADDR, default 16'h8000, byte address of the first dumped word.
REQ-004 Parameter DUMP_WORDS, default 32, number of words dumped; minimum 1.
REQ-005 Parameter TIMEOUT, default 1000000, run-cycle limit before a forced dump; minimum 2.
REQ-006 Port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-007 Port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-008 Port hcf, input, 1, CPU halt-and-catch-fire level from the core.
REQ-009 Port mem_req, output, 1, one-cycle read request strobe.
REQ-010 Port mem_addr, output, ADDR_W, read byte address; valid while mem_req=1.
REQ-011 Port mem_rvalid, input, 1, read data valid, returned 1..N cycles after mem_req.
REQ-012 Port mem_rdata, input, DATA_W, read data; sampled only when mem_rvalid=1.
REQ-013 Port dout_valid, output, 1, dump word available.
REQ-014 Port dout_ready, input, 1, consumer accepts dump word.
REQ-015 Port dout_addr, output, ADDR_W, byte address of the current dump word.
REQ-016 Port dout_data, output, DATA_W, current dump word.
REQ-017 Port done, output, 1, dump complete; sticky.
REQ-018 Port timeout, output, 1, dump was forced by TIMEOUT rather than hcf; sticky.
REQ-019 Port cycle_count, output, 32, run cycles elapsed before the halt/timeout.

Function
REQ-020 The FSM SHALL have exactly the states RUN, REQ, WAIT, OUT, DONE.
REQ-021 In RUN, cycle_count SHALL increment by 1 per cycle, saturating at 32'hFFFFFFFF.
REQ-022 In RUN, hcf=1 SHALL move the FSM to REQ next cycle, load the address with BASE_ADDR, clear the word index, and freeze cycle_count.
REQ-023 In RUN, with hcf=0 and cycle_count = TIMEOUT-1, the FSM SHALL set timeout=1 and move to REQ, as in REQ-022.
REQ-024 When hcf=1 and the timeout condition occur in the same cycle, hcf SHALL win and timeout SHALL stay 0.
REQ-025 In REQ, mem_req SHALL be 1 for exactly one cycle with mem_addr = the current address; the FSM then moves to WAIT.
REQ-026 In WAIT, mem_rvalid=1 SHALL capture mem_rdata into dout_data and move to OUT; mem_rvalid in any other state SHALL be ignored.
REQ-027 In OUT, dout_valid SHALL be 1, and dout_data/dout_addr SHALL be held stable until dout_valid&dout_ready.
REQ-028 On the OUT handshake with index = DUMP_WORDS-1, the FSM SHALL move to DONE; otherwise index+1, address += DATA_W/8, then REQ.
REQ-029 Address arithmetic SHALL wrap modulo 2^ADDR_W; e.g. 16'hFFFC+4 = 16'h0000.
REQ-030 Minimum word latency SHALL be 3 cycles (REQ, WAIT with rvalid, OUT with ready).
REQ-031 In DONE, done SHALL be 1, mem_req and dout_valid SHALL be 0, hcf SHALL be ignored, and the FSM SHALL stay in DONE until reset.
REQ-032 After the trigger, hcf changes (deassert/reassert) SHALL have no effect.
REQ-033 dout_ready while dout_valid=0 SHALL have no effect.

Reset
REQ-034 rst=0 SHALL, asynchronously, force RUN: cycle_count=0, mem_req=0, mem_addr=0, dout_valid=0, dout_addr=0, dout_data=0, done=0, timeout=0.
REQ-035 Reset asserted in any state, including mid-dump, SHALL abort the dump with no further mem_req; operation resumes from RUN on the first edge after rst=1.

Verification
REQ-036 Defaults: hcf=1 at run cycle 100; memory returns rdata=addr with 2-cycle latency; ready tied 1 -> 32 words, addresses 8000..807C step 4; cycle_count=100; done=1; timeout=0.
REQ-037 TIMEOUT=50, hcf never asserted -> timeout=1; dump starts with mem_addr=8000; cycle_count=49.
REQ-038 TIMEOUT=50 and hcf=1 at the cycle where cycle_count=49 -> timeout=0.
REQ-039 dout_ready toggled 0,0,1 in a pattern -> dout_data/dout_addr stable while valid&!ready; no words lost or duplicated.
REQ-040 BASE_ADDR=16'hFFF8, DUMP_WORDS=4 -> addresses FFF8, FFFC, 0000, 0004.
REQ-041 rst=0 pulsed during word 5 WAIT -> outputs reset immediately; a later hcf restarts the dump at 8000.
